// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game.
// Holds the default LFSR width, the LFSR tap positions (1-based, XNOR
// feedback) used by every LFSR in the game, the computer-player FSM state
// type and the feedback helper.
package tug_pkg;

   localparam int unsigned LFSR_W_DEFAULT = 10;

   // Taps 10,7 with XNOR feedback: maximal length (1023), lockup at all-ones.
   localparam int unsigned LFSR_TAP_HI = 10;
   localparam int unsigned LFSR_TAP_LO = 7;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      COOL
   } cpu_state_t;

   function automatic logic lfsr_feedback(input logic hi, input logic lo);
      return ~(hi ^ lo);
   endfunction

endpackage

// File: rtl/tug_lfsr.sv
// Fibonacci XNOR LFSR that shifts left every cycle.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; clears the register to all-zeros
//   q     - current LFSR state
// Starting from zero the all-ones lockup state is never reached.
module tug_lfsr
   import tug_pkg::*;
#(
   parameter int unsigned Width = LFSR_W_DEFAULT,
   parameter int unsigned TapHi = LFSR_TAP_HI,
   parameter int unsigned TapLo = LFSR_TAP_LO
) (
   input  logic             clk,
   input  logic             reset,
   output logic [Width-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= {q[Width-2:0], lfsr_feedback(q[TapHi-1], q[TapLo-1])};
      end
   end

endmodule

// File: rtl/tug_player_driver.sv
// Move-pulse generator for the tug-of-war playfield.
// The human path synchronizes and edge-detects the push-button; the computer
// path fires when the LFSR is below the difficulty setting, then cools down.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high
//   key_raw    - asynchronous human button, active-high
//   enable     - game running; no pulses while low
//   difficulty - fire threshold; larger means a faster computer
//   Rin        - registered one-cycle human press pulse
//   Lin        - registered one-cycle computer press pulse
//   lfsr_q     - current LFSR state (debug/HEX)
// Rin and Lin are never high in the same cycle.
module tug_player_driver
   import tug_pkg::*;
#(
   parameter int unsigned LFSR_W   = LFSR_W_DEFAULT,
   parameter int unsigned COOLDOWN = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_raw,
   input  logic              enable,
   input  logic [LFSR_W-1:0] difficulty,
   output logic              Rin,
   output logic              Lin,
   output logic [LFSR_W-1:0] lfsr_q
);

   localparam int unsigned     CntW    = $clog2(COOLDOWN + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(COOLDOWN);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   logic            s1_q, s2_q, prev_q;
   logic            press, fire;
   logic            rin_q, lin_q;
   cpu_state_t      state_q;
   logic [CntW-1:0] cnt_q;

   tug_lfsr #(
      .Width (LFSR_W),
      .TapHi (LFSR_TAP_HI),
      .TapLo (LFSR_TAP_LO)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   // Two-flop synchronizer plus previous-value register for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= key_raw;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign press = s2_q & ~prev_q;
   assign fire  = (lfsr_q < difficulty);

   always_ff @(posedge clk) begin
      if (reset) begin
         rin_q <= 1'b0;
      end else begin
         rin_q <= press & enable;
      end
   end

   // Computer player. A tie with a human press defers Lin by one cycle via
   // PEND; since press cannot recur next cycle, Lin never overlaps Rin.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lin_q   <= 1'b0;
      end else begin
         lin_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable && fire) begin
                  if (press) begin
                     state_q <= PEND;
                  end else begin
                     lin_q   <= 1'b1;
                     cnt_q   <= CntLoad;
                     state_q <= COOL;
                  end
               end
            end
            PEND: begin
               if (enable) begin
                  lin_q   <= 1'b1;
                  cnt_q   <= CntLoad;
                  state_q <= COOL;
               end else begin
                  state_q <= IDLE;
               end
            end
            COOL: begin
               // Keeps counting even while disabled.
               cnt_q <= cnt_q - CntOne;
               if (cnt_q == CntOne) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Rin = rin_q;
   assign Lin = lin_q;

endmodule
